// File: rtl/intlv_table_seq.sv
// intlv_table_seq: multi-table turbo-interleaver address sequencer.
// N_TABLES permutation tables share one synchronous memory addressed {tbl,idx}.
// A run streams table[tbl][0..len-1] (or the identity sequence) over valid/ready
// and pulses done once the final beat has been accepted.
module intlv_table_seq #(
   parameter int unsigned  D_WIDTH   = 13,
   parameter int unsigned  A_WIDTH   = 13,
   parameter int unsigned  N_TABLES  = 4,
   parameter               INIT_FILE = "",
   localparam int unsigned T_WIDTH   = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               wr_en,
   input  logic [T_WIDTH-1:0] wr_tbl,
   input  logic [A_WIDTH-1:0] wr_addr,
   input  logic [D_WIDTH-1:0] wr_data,
   output logic               wr_err,
   input  logic               start,
   input  logic [T_WIDTH-1:0] tbl_sel,
   input  logic               mode,
   input  logic [A_WIDTH:0]   len,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [D_WIDTH-1:0] out_data,
   output logic               done
);

   localparam int unsigned      DEPTH   = N_TABLES * (2 ** A_WIDTH);
   localparam int unsigned      M_AW    = T_WIDTH + A_WIDTH;
   // One extra bit so that N_TABLES == 2**T_WIDTH still compares correctly.
   localparam logic [T_WIDTH:0] TBL_LIM = (T_WIDTH + 1)'(N_TABLES);
   localparam logic [A_WIDTH:0] ONE     = (A_WIDTH + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             state;
   // idx is one bit wider than an entry index so len == 2**A_WIDTH never overflows.
   logic [A_WIDTH:0]   idx;
   logic [A_WIDTH:0]   len_q;
   logic [T_WIDTH-1:0] tbl_q;
   logic               mode_q;

   logic [D_WIDTH-1:0] mem [DEPTH];

   logic               wr_tbl_ok;
   logic               wr_ok;
   logic               sel_ok;
   logic               issue;
   logic               last;
   logic [M_AW-1:0]    wr_maddr;
   logic [M_AW-1:0]    rd_maddr;

   assign wr_tbl_ok = ({1'b0, wr_tbl} < TBL_LIM);
   assign wr_ok     = wr_en && (state == S_IDLE) && wr_tbl_ok;
   assign sel_ok    = ({1'b0, tbl_sel} < TBL_LIM);
   // A new read may be issued whenever the output register is empty or draining this cycle.
   assign issue     = (state == S_RUN) && (!out_valid || out_ready);
   assign last      = (idx == (len_q - ONE));
   assign wr_maddr  = {wr_tbl, wr_addr};
   assign rd_maddr  = {tbl_q, idx[A_WIDTH-1:0]};

   // Table write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_maddr] <= wr_data;
      end
   end

   // Sticky flag for writes dropped because a run is active or the table is out of range.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_err <= 1'b0;
      end else if (wr_en && !wr_ok) begin
         wr_err <= 1'b1;
      end
   end

   // Run sequencer: IDLE accepts a start, RUN issues reads, DRAIN waits for the final beat.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         done      <= 1'b0;
         idx       <= '0;
         len_q     <= '0;
         tbl_q     <= '0;
         mode_q    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && sel_ok) begin
                  if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state  <= S_RUN;
                     busy   <= 1'b1;
                     idx    <= '0;
                     len_q  <= len;
                     tbl_q  <= tbl_sel;
                     mode_q <= mode;
                  end
               end
            end
            S_RUN: begin
               if (issue) begin
                  out_valid <= 1'b1;
                  out_data  <= mode_q ? D_WIDTH'(idx[A_WIDTH-1:0]) : mem[rd_maddr];
                  if (last) begin
                     idx   <= '0;
                     state <= S_DRAIN;
                  end else begin
                     idx <= idx + ONE;
                  end
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
